mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch stage and the data load/store stage of `pipeline`. It arbitrates with data priority and a starvation guard for fetch, and tracks one outstanding transaction. It routes the response back to the owning requester and can discard an in-flight fetch on a PC redirect. It sits between the pipeline's `inst_addr`/`data_addr` side and the external memory bus.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory port arbiter.
// Owner and state encodings plus the fixed fetch byte mask.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IF,
      ARB_D
   } arb_state_t;

   typedef enum logic {
      OWNER_IF,
      OWNER_D
   } arb_owner_t;

   localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store.
// Data-priority arbitration with fetch starvation guard and flush drop.
module mem_port_arbiter
   import pipeline_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

   arb_state_t state_q, state_d;
   arb_owner_t sel_q, sel_d;
   logic       lock_q, lock_d;
   logic       drop_q, drop_d;
   logic [3:0] starve_q, starve_d;

   arb_owner_t pick;
   arb_owner_t sel;
   logic       sel_req;
   logic [3:0] starve_inc;

   // Fresh choice: data first unless fetch has waited too long.
   always_comb begin
      pick = OWNER_D;
      if (d_req && (starve_q < LIMIT)) begin
         pick = OWNER_D;
      end else if (if_req) begin
         pick = OWNER_IF;
      end
   end

   // A stalled command keeps its requester until the bus accepts it.
   assign sel     = lock_q ? sel_q : pick;
   assign sel_req = (sel == OWNER_D) ? d_req : if_req;

   assign starve_inc = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;

   // Next state, command mux, grant and response routing.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      lock_d    = lock_q;
      drop_d    = drop_q;
      starve_d  = starve_q;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ARB_IDLE: begin
            if (sel_req) begin
               mem_req = 1'b1;
               if (sel == OWNER_D) begin
                  mem_we    = d_we;
                  mem_be    = d_be;
                  mem_addr  = d_addr;
                  mem_wdata = d_wdata;
               end else begin
                  mem_be    = FETCH_BE;
                  mem_addr  = if_addr;
               end
               if (!mem_gnt) begin
                  lock_d = 1'b1;
                  sel_d  = sel;
               end else begin
                  lock_d = 1'b0;
                  if (sel == OWNER_D) begin
                     d_gnt    = 1'b1;
                     state_d  = ARB_D;
                     starve_d = if_req ? starve_inc : 4'd0;
                  end else begin
                     if_gnt   = 1'b1;
                     state_d  = ARB_IF;
                     starve_d = 4'd0;
                  end
               end
            end
         end
         ARB_IF: begin
            drop_d = drop_q | if_flush;
            if (mem_rvalid) begin
               if (!(drop_q || if_flush)) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end
               drop_d  = 1'b0;
               state_d = ARB_IDLE;
            end
         end
         ARB_D: begin
            if (mem_rvalid) begin
               d_rvalid = 1'b1;
               d_rdata  = mem_rdata;
               state_d  = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State, lock, drop flag and starvation counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ARB_IDLE;
         sel_q    <= OWNER_D;
         lock_q   <= 1'b0;
         drop_q   <= 1'b0;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         lock_q   <= lock_d;
         drop_q   <= drop_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for the memory port arbiter.
// Inputs change 1ns after a rising edge, outputs are checked 1ns later.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int total;
   int bad;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_idle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   logic [5:0] exp_dgnt;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0;
      d_addr = '0; d_wdata = '0;
      bus_idle();
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // fetch only
      if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
      #1;
      chk("f_mem_req", {31'd0, mem_req}, 32'd1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_be", {28'd0, mem_be}, 32'hF);
      chk("f_mem_we", {31'd0, mem_we}, 32'd0);
      chk("f_if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("f_d_gnt", {31'd0, d_gnt}, 32'd0);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0;
      #1;
      chk("f_wait_req", {31'd0, mem_req}, 32'd0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("f_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
      chk("f_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("f_d_rdata", d_rdata, 32'd0);
      tick();
      bus_idle();

      // simultaneous requests, data store wins
      if_req = 1'b1; if_addr = 32'h104;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
      d_addr = 32'h200; d_wdata = 32'h0000_55AA;
      mem_gnt = 1'b1;
      #1;
      chk("s_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("s_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("s_mem_we", {31'd0, mem_we}, 32'd1);
      chk("s_mem_be", {28'd0, mem_be}, 32'h3);
      chk("s_mem_addr", mem_addr, 32'h200);
      chk("s_mem_wdata", mem_wdata, 32'h55AA);
      tick();
      d_req = 1'b0; d_we = 1'b0; mem_gnt = 1'b0;
      #1;
      chk("s_wait_req", {31'd0, mem_req}, 32'd0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h0;
      #1;
      chk("s_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("s_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      tick();
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      #1;
      chk("s_if_gnt2", {31'd0, if_gnt}, 32'd1);
      chk("s_mem_addr2", mem_addr, 32'h104);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      #1;
      chk("s_if_rdata", if_rdata, 32'h1111_2222);
      tick();
      bus_idle();

      // starvation guard: D,D,D,D,IF,D
      exp_dgnt = 6'b101111;
      if_req = 1'b1; if_addr = 32'h180;
      d_req = 1'b1; d_addr = 32'h280; d_be = 4'hF;
      for (int i = 0; i < 6; i++) begin
         mem_gnt = 1'b1; mem_rvalid = 1'b0;
         #1;
         chk($sformatf("st_d_gnt%0d", i), {31'd0, d_gnt},
             {31'd0, exp_dgnt[i]});
         chk($sformatf("st_if_gnt%0d", i), {31'd0, if_gnt},
             {31'd0, ~exp_dgnt[i]});
         tick();
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7;
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      bus_idle();
      tick();

      // bus stall with fetch locked, data arrives later
      if_req = 1'b1; if_addr = 32'h300;
      #1;
      chk("b_addr0", mem_addr, 32'h300);
      chk("b_gnt0", {31'd0, if_gnt}, 32'd0);
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      #1;
      chk("b_addr1", mem_addr, 32'h300);
      chk("b_dgnt1", {31'd0, d_gnt}, 32'd0);
      tick();
      #1;
      chk("b_addr2", mem_addr, 32'h300);
      tick();
      mem_gnt = 1'b1;
      #1;
      chk("b_if_gnt3", {31'd0, if_gnt}, 32'd1);
      chk("b_d_gnt3", {31'd0, d_gnt}, 32'd0);
      chk("b_addr3", mem_addr, 32'h300);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hA5A5;
      #1;
      chk("b_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      tick();
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      #1;
      chk("b_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("b_d_addr", mem_addr, 32'h400);
      tick();
      d_req = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h4444;
      #1;
      chk("b_d_rdata", d_rdata, 32'h4444);
      tick();
      bus_idle();

      // flush of outstanding fetch
      if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
      #1;
      chk("fl_gnt", {31'd0, if_gnt}, 32'd1);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0; if_flush = 1'b1;
      tick();
      if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
      #1;
      chk("fl_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("fl_rdata", if_rdata, 32'd0);
      chk("fl_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      tick();
      mem_rvalid = 1'b0;
      if_req = 1'b1; if_addr = 32'h504; mem_gnt = 1'b1;
      #1;
      chk("fl_next_gnt", {31'd0, if_gnt}, 32'd1);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
      #1;
      chk("fl_next_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("fl_next_rdata", if_rdata, 32'hCAFE);
      tick();
      bus_idle();

      // stray response in idle
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
      #1;
      chk("idle_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      tick();
      bus_idle();

      // reset during data transaction
      d_req = 1'b1; d_addr = 32'h600; mem_gnt = 1'b1;
      #1;
      chk("r_d_gnt", {31'd0, d_gnt}, 32'd1);
      tick();
      d_req = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h6666;
      #1;
      chk("r_pre_rvalid", {31'd0, d_rvalid}, 32'd1);
      reset = 1'b0;
      #1;
      chk("r_async_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("r_async_rdata", d_rdata, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("r_stale_d", {31'd0, d_rvalid}, 32'd0);
      chk("r_stale_if", {31'd0, if_rvalid}, 32'd0);
      tick();
      bus_idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
